// File: rtl/ex_mcycle_ctrl_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the EX multi-cycle sequencer.
package ex_mcycle_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] MC_NONE = 3'd0;
   localparam logic [OP_W-1:0] MADD    = 3'd1;
   localparam logic [OP_W-1:0] MADDU   = 3'd2;
   localparam logic [OP_W-1:0] MSUB    = 3'd3;
   localparam logic [OP_W-1:0] MSUBU   = 3'd4;
   localparam logic [OP_W-1:0] DIV     = 3'd5;
   localparam logic [OP_W-1:0] DIVU    = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DIVW = 2'd2
   } mc_state_e;

   function automatic logic is_madd_class(input logic [OP_W-1:0] op);
      return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
   endfunction

   function automatic logic is_div_class(input logic [OP_W-1:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [OP_W-1:0] op);
      return (op == MADD) || (op == MSUB) || (op == DIV);
   endfunction

   function automatic logic is_sub_op(input logic [OP_W-1:0] op);
      return (op == MSUB) || (op == MSUBU);
   endfunction

endpackage

// File: rtl/ex_mcycle_ctrl_if.sv
// EX-side operand/HI-LO bus plus the external divider handshake for the multi-cycle sequencer.
interface ex_mcycle_ctrl_if;
   import ex_mcycle_ctrl_pkg::*;

   logic                op_valid;
   logic [OP_W-1:0]     op;
   logic [DATA_W-1:0]   opa;
   logic [DATA_W-1:0]   opb;
   logic [DATA_W-1:0]   hi;
   logic [DATA_W-1:0]   lo;
   logic                flush;
   logic                div_ready;
   logic [2*DATA_W-1:0] div_result;

   logic                div_start;
   logic                div_cancel;
   logic                div_signed;
   logic [DATA_W-1:0]   div_opa;
   logic [DATA_W-1:0]   div_opb;
   logic                stallreq;
   logic                whilo;
   logic [DATA_W-1:0]   hi_wr;
   logic [DATA_W-1:0]   lo_wr;

   modport master (
      output op_valid, op, opa, opb, hi, lo, flush, div_ready, div_result,
      input  div_start, div_cancel, div_signed, div_opa, div_opb,
             stallreq, whilo, hi_wr, lo_wr
   );

   modport slave (
      input  op_valid, op, opa, opb, hi, lo, flush, div_ready, div_result,
      output div_start, div_cancel, div_signed, div_opa, div_opb,
             stallreq, whilo, hi_wr, lo_wr
   );

endinterface

// File: rtl/ex_mcycle_ctrl.sv
// EX multi-cycle sequencer: MADD-class in 2 cycles (1 stall), DIV in 1 + divider latency.
// Stall, HI/LO write enable and data are Mealy outputs valid in the cycle of their inputs.
module ex_mcycle_ctrl
   import ex_mcycle_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   ex_mcycle_ctrl_if.slave mc
);

   mc_state_e           state_q, state_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   dopa_q, dopa_d;
   logic [DATA_W-1:0]   dopb_q, dopb_d;
   logic                dsign_q, dsign_d;

   logic [2*DATA_W-1:0] mult_a, mult_b, product, product_adj, hilo_cur;

   logic                start, cancel, stall, wen, osign;
   logic [DATA_W-1:0]   oopa, oopb;
   logic [2*DATA_W-1:0] wdata;

   // Extending to 64 bits first makes the low 64 bits of one multiply correct for both signednesses.
   always_comb begin
      mult_a = is_signed_op(mc.op) ? {{DATA_W{mc.opa[DATA_W-1]}}, mc.opa}
                                   : {{DATA_W{1'b0}}, mc.opa};
      mult_b = is_signed_op(mc.op) ? {{DATA_W{mc.opb[DATA_W-1]}}, mc.opb}
                                   : {{DATA_W{1'b0}}, mc.opb};
      product     = mult_a * mult_b;
      product_adj = is_sub_op(mc.op) ? (~product + 64'd1) : product;
      hilo_cur    = {mc.hi, mc.lo};
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dopa_d  = dopa_q;
      dopb_d  = dopb_q;
      dsign_d = dsign_q;
      start   = 1'b0;
      cancel  = 1'b0;
      stall   = 1'b0;
      wen     = 1'b0;
      osign   = 1'b0;
      oopa    = '0;
      oopb    = '0;
      wdata   = '0;

      if (rst) begin
         // The divider shares rst, so no cancel pulse is needed here.
         state_d = IDLE;
         acc_d   = '0;
      end else if (mc.flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cancel  = (state_q == DIVW);
      end else begin
         case (state_q)
            IDLE: begin
               if (mc.op_valid && is_madd_class(mc.op)) begin
                  acc_d   = product_adj;
                  stall   = 1'b1;
                  state_d = ACC;
               end else if (mc.op_valid && is_div_class(mc.op)) begin
                  if (mc.opb == '0) begin
                     wen = 1'b1;
                  end else begin
                     dopa_d  = mc.opa;
                     dopb_d  = mc.opb;
                     dsign_d = (mc.op == DIV);
                     stall   = 1'b1;
                     state_d = DIVW;
                  end
               end
            end
            ACC: begin
               // HI/LO are taken in this cycle so a write retiring in MEM/WB meanwhile is seen.
               wdata   = hilo_cur + acc_q;
               wen     = 1'b1;
               acc_d   = '0;
               state_d = IDLE;
            end
            DIVW: begin
               start = 1'b1;
               oopa  = dopa_q;
               oopb  = dopb_q;
               osign = dsign_q;
               stall = ~mc.div_ready;
               if (mc.div_ready) begin
                  wen     = 1'b1;
                  wdata   = mc.div_result;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         dopa_q  <= '0;
         dopb_q  <= '0;
         dsign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dopa_q  <= dopa_d;
         dopb_q  <= dopb_d;
         dsign_q <= dsign_d;
      end
   end

   assign mc.div_start  = start;
   assign mc.div_cancel = cancel;
   assign mc.div_signed = osign;
   assign mc.div_opa    = oopa;
   assign mc.div_opb    = oopb;
   assign mc.stallreq   = stall;
   assign mc.whilo      = wen;
   assign mc.hi_wr      = wdata[2*DATA_W-1:DATA_W];
   assign mc.lo_wr      = wdata[DATA_W-1:0];

endmodule

// File: tb/tb_ex_mcycle_ctrl.sv
// Directed bench for ex_mcycle_ctrl: inputs change 1 time unit after posedge, outputs checked at negedge.
module tb_ex_mcycle_ctrl;
   import ex_mcycle_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ex_mcycle_ctrl_if mc_if ();

   ex_mcycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .mc  (mc_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b);
      mc_if.op_valid = v;
      mc_if.op       = o;
      mc_if.opa      = a;
      mc_if.opb      = b;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive_op(1'b1, MADD, 32'h5, 32'h6);
      mc_if.hi         = 32'h1;
      mc_if.lo         = 32'h2;
      mc_if.flush      = 1'b0;
      mc_if.div_ready  = 1'b0;
      mc_if.div_result = '0;

      // reset cycle with an op presented: everything quiet
      @(negedge clk);
      chk("rst_stall", mc_if.stallreq, 0);
      chk("rst_whilo", mc_if.whilo, 0);
      chk("rst_start", mc_if.div_start, 0);
      chk("rst_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 0);
      next_cycle();

      rst = 1'b0;
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      @(negedge clk);
      chk("idle_stall", mc_if.stallreq, 0);
      chk("idle_whilo", mc_if.whilo, 0);
      chk("idle_cancel", mc_if.div_cancel, 0);
      chk("idle_divops", {mc_if.div_signed, mc_if.div_opa, mc_if.div_opb}, 0);
      next_cycle();

      // MADD: lo changes between cycles; the second-cycle value must be used
      drive_op(1'b1, MADD, 32'hFFFF_FFFE, 32'd3);
      mc_if.hi = 32'h0;
      mc_if.lo = 32'h99;
      @(negedge clk);
      chk("madd_c1_stall", mc_if.stallreq, 1);
      chk("madd_c1_whilo", mc_if.whilo, 0);
      next_cycle();
      mc_if.lo = 32'h10;
      @(negedge clk);
      chk("madd_c2_whilo", mc_if.whilo, 1);
      chk("madd_c2_stall", mc_if.stallreq, 0);
      chk("madd_c2_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'h0000_0000_0000_000A);
      next_cycle();

      // MSUBU back-to-back, no dead cycle
      drive_op(1'b1, MSUBU, 32'hFFFF_FFFF, 32'd2);
      mc_if.hi = 32'h0;
      mc_if.lo = 32'h0;
      @(negedge clk);
      chk("msubu_c1_stall", mc_if.stallreq, 1);
      next_cycle();
      @(negedge clk);
      chk("msubu_c2_whilo", mc_if.whilo, 1);
      chk("msubu_c2_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'hFFFF_FFFE_0000_0002);
      next_cycle();

      // MSUB signed: 20 - 3*4 = 8
      drive_op(1'b1, MSUB, 32'd3, 32'd4);
      mc_if.lo = 32'd20;
      @(negedge clk);
      chk("msub_c1_stall", mc_if.stallreq, 1);
      next_cycle();
      @(negedge clk);
      chk("msub_c2_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'h0000_0000_0000_0008);
      next_cycle();

      // MADDU: unsigned 0xFFFFFFFF^2 (signed would give 1)
      drive_op(1'b1, MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      mc_if.lo = 32'h0;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("maddu_c2_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'hFFFF_FFFE_0000_0001);
      next_cycle();

      // signed DIV -7/2 with 34 stall cycles
      drive_op(1'b1, DIV, 32'hFFFF_FFF9, 32'd2);
      @(negedge clk);
      chk("div_c0_stall", mc_if.stallreq, 1);
      chk("div_c0_start", mc_if.div_start, 0);
      next_cycle();
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         chk("divw_stall", mc_if.stallreq, 1);
         chk("divw_start", mc_if.div_start, 1);
         if (i == 0) begin
            chk("divw_signed", mc_if.div_signed, 1);
            chk("divw_ops", {mc_if.div_opa, mc_if.div_opb}, 64'hFFFF_FFF9_0000_0002);
         end
         next_cycle();
      end
      mc_if.div_ready  = 1'b1;
      mc_if.div_result = 64'hFFFF_FFFF_FFFF_FFFD;
      @(negedge clk);
      chk("div_done_whilo", mc_if.whilo, 1);
      chk("div_done_stall", mc_if.stallreq, 0);
      chk("div_done_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'hFFFF_FFFF_FFFF_FFFD);
      next_cycle();
      mc_if.div_ready = 1'b0;
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      @(negedge clk);
      chk("div_after_start", mc_if.div_start, 0);
      chk("div_after_whilo", mc_if.whilo, 0);
      next_cycle();

      // DIVU by zero completes at once
      drive_op(1'b1, DIVU, 32'd1234, 32'd0);
      mc_if.hi = 32'h5555_5555;
      mc_if.lo = 32'hAAAA_AAAA;
      @(negedge clk);
      chk("div0_whilo", mc_if.whilo, 1);
      chk("div0_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 0);
      chk("div0_stall", mc_if.stallreq, 0);
      chk("div0_start", mc_if.div_start, 0);
      next_cycle();
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      @(negedge clk);
      chk("div0_next_start", mc_if.div_start, 0);
      chk("div0_next_whilo", mc_if.whilo, 0);
      next_cycle();

      // DIVU flushed on the 5th DIVW cycle; stray ready afterwards
      drive_op(1'b1, DIVU, 32'd100, 32'd7);
      @(negedge clk);
      chk("fl_c0_stall", mc_if.stallreq, 1);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fl_divw_start", mc_if.div_start, 1);
         if (i == 0) chk("fl_divw_signed", mc_if.div_signed, 0);
         next_cycle();
      end
      mc_if.flush = 1'b1;
      @(negedge clk);
      chk("fl_cancel", mc_if.div_cancel, 1);
      chk("fl_stall", mc_if.stallreq, 0);
      chk("fl_whilo", mc_if.whilo, 0);
      next_cycle();
      mc_if.flush      = 1'b0;
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      mc_if.div_ready  = 1'b1;
      mc_if.div_result = 64'h0000_0002_0000_000E;
      @(negedge clk);
      chk("stray_whilo", mc_if.whilo, 0);
      chk("stray_cancel", mc_if.div_cancel, 0);
      chk("stray_start", mc_if.div_start, 0);
      chk("stray_stall", mc_if.stallreq, 0);
      next_cycle();
      mc_if.div_ready = 1'b0;

      // rst during ACC, then a clean MADD: 1 + 2*3 = 7
      drive_op(1'b1, MADD, 32'd5, 32'd5);
      mc_if.hi = 32'h0;
      mc_if.lo = 32'h0;
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rstacc_whilo", mc_if.whilo, 0);
      chk("rstacc_stall", mc_if.stallreq, 0);
      next_cycle();
      rst = 1'b0;
      drive_op(1'b1, MADD, 32'd2, 32'd3);
      mc_if.lo = 32'd1;
      @(negedge clk);
      chk("post_rst_c1_stall", mc_if.stallreq, 1);
      next_cycle();
      @(negedge clk);
      chk("post_rst_c2_whilo", mc_if.whilo, 1);
      chk("post_rst_c2_hilo", {mc_if.hi_wr, mc_if.lo_wr}, 64'h0000_0000_0000_0007);
      next_cycle();

      // rst during DIVW gives no cancel pulse
      drive_op(1'b1, DIV, 32'd10, 32'd3);
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rstdiv_cancel", mc_if.div_cancel, 0);
      chk("rstdiv_start", mc_if.div_start, 0);
      chk("rstdiv_stall", mc_if.stallreq, 0);
      next_cycle();
      rst = 1'b0;
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      @(negedge clk);
      chk("rstdiv_idle_start", mc_if.div_start, 0);
      next_cycle();

      // flush during ACC: no write, no cancel
      drive_op(1'b1, MADD, 32'd1, 32'd1);
      @(negedge clk);
      next_cycle();
      mc_if.flush = 1'b1;
      @(negedge clk);
      chk("flacc_whilo", mc_if.whilo, 0);
      chk("flacc_cancel", mc_if.div_cancel, 0);
      chk("flacc_stall", mc_if.stallreq, 0);
      next_cycle();
      mc_if.flush = 1'b0;
      drive_op(1'b0, MC_NONE, 32'h0, 32'h0);
      @(negedge clk);
      chk("flacc_idle_whilo", mc_if.whilo, 0);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
